dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- FIXED_PRI, 0; 0 selects round-robin, 1 selects fixed priority with m0 highest.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- m0_req, input, 1, requester 0 access request; held until m0_gnt.
- m0_we, input, 1, requester 0 write enable (1 = write, 0 = read).
- m0_addr, input, ADDR_W, requester 0 byte address.
- m0_wdata, input, DATA_W, requester 0 write data.
- m0_gnt, output, 1, one-cycle pulse: requester 0 access issued to memory.
- m0_rvalid, output, 1, one-cycle pulse: m0_rdata valid.
- m0_rdata, output, DATA_W, requester 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the m0 ports, for requester 1.
- mem_addr, output, ADDR_W, address to the data memory.
- mem_wdata, output, DATA_W, write data to the data memory.
- mem_read, output, 1, read strobe to the data memory.
- mem_write, output, 1, write strobe to the data memory.
- mem_rdata, input, DATA_W, combinational read data returned by the data memory for mem_addr.
- busy, output, 1, high whenever the state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and RESP.

REQ-004 IDLE:
- If any mN_req=1 at a clock edge, the block SHALL latch the winner's we, addr and wdata, record the winner index, and go to ACCESS.
- Otherwise it SHALL stay in IDLE.

REQ-005 Winner selection:
- FIXED_PRI=1: m0 wins whenever m0_req=1.
- FIXED_PRI=0: with both requesting, the requester not granted last wins; with one requesting, that requester wins.

REQ-006 The round-robin last-grant pointer SHALL update only on entry to ACCESS; after reset it SHALL point to m1, so m0 wins the first tie.

REQ-007 ACCESS (always exactly one cycle):
- mem_addr and mem_wdata SHALL be driven from the latched request.
- mem_write SHALL equal the latched we; mem_read SHALL equal its inverse.
- The winner's mN_gnt SHALL be 1; the other requester's gnt SHALL be 0.

REQ-008 Leaving ACCESS:
- Write: go to IDLE.
- Read: capture mem_rdata into the winner's rdata register at the end of ACCESS, then go to RESP.

REQ-009 RESP SHALL assert the winner's mN_rvalid for one cycle and then go to IDLE.

REQ-010 Latency, for a request seen in IDLE at edge T:
- gnt SHALL be high in cycle T+1.
- For reads, rvalid SHALL be high in cycle T+2.
- Minimum issue spacing SHALL be 2 cycles for writes and 3 cycles for reads.

REQ-011 Request signals sampled outside IDLE SHALL be ignored. A requester that drops mN_req after the latch edge SHALL NOT cancel the access.

REQ-012 Outside ACCESS:
- mem_read and mem_write SHALL be 0.
- mem_addr and mem_wdata SHALL hold their last values.

REQ-013 mN_rdata SHALL hold its last captured value until that requester's next read. It SHALL be updated only for the requester that won the read.

REQ-014 At most one of m0_gnt and m1_gnt, and at most one of m0_rvalid and m1_rvalid, SHALL be high in any cycle.

REQ-015 Under round-robin, a continuously requesting master SHALL wait for at most one access by the other master.

REQ-016 Addresses SHALL pass through unmodified; range checking and alignment are outside this block.

Reset
REQ-017 reset=0 SHALL asynchronously force:
- state to IDLE and the pointer to m1;
- all gnt, rvalid, mem_read, mem_write and busy outputs to 0;
- mem_addr, mem_wdata and both rdata registers to 0.

REQ-018 An access in progress when reset asserts SHALL be dropped, with no gnt or rvalid after reset is released. Arbitration SHALL resume at the first edge with reset=1.

Structure
REQ-019 Package dmem_arb_pkg SHALL hold the state typedef (IDLE, ACCESS, RESP) and the master index constants M0=0 and M1=1.

REQ-020 The 2-way picker (request vector, last-grant pointer and FIXED_PRI in; winner index out) SHALL be the sub-module rr_pick2. All other logic SHALL stay in dmem_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single read: m0 reads 0x10 with memory returning 0xDEADBEEF -> m0_gnt at T+1; mem_read=1 with mem_addr=0x10 at T+1; m0_rvalid=1 with m0_rdata=0xDEADBEEF at T+2; busy low at T+3.
- Single write: m1 writes 0xCAFEF00D to 0x20 -> mem_write=1, mem_addr=0x20, mem_wdata=0xCAFEF00D and m1_gnt for one cycle at T+1; no rvalid; IDLE at T+2.
- Tie after reset, round-robin: both masters hold reads -> m0 granted first, then m1, then m0 again; gnt never overlaps.
- FIXED_PRI=1 with m0 requesting continuously -> m1 is never granted while m0_req=1; m1 is granted the first time m0_req drops in IDLE.
- Reset mid-read: reset=0 during ACCESS of an m0 read -> mem_read drops immediately; no m0_rvalid after release; next request is granted normally.
- Reads back-to-back from one master: m0 reads 0x4, 0x8 and 0xC -> gnt every 3 cycles; each rdata matches its own address.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and constants for the data-memory arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way winner picker, round-robin or fixed priority (m0 highest)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_pick2 #(
  parameter int FIXED_PRI = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);
  import dmem_arb_pkg::*;

  generate
    if (FIXED_PRI != 0) begin : g_fixed
      assign win = req[0] ? M0 : M1;
    end else begin : g_rr
      // On a tie the master that was not granted last goes next.
      assign win = (req == 2'b11) ? ~last : (req[0] ? M0 : M1);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-master arbiter in front of a single-port data memory
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import dmem_arb_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          req_vec;
  logic                win;
  logic                win_q;
  logic                last;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                take;

  assign req_vec = {m1_req, m0_req};
  assign take    = (state == IDLE) && (req_vec != 2'b00);

  rr_pick2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .req  (req_vec),
    .last (last),
    .win  (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (req_vec != 2'b00) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_write = lat_we;
        mem_read  = ~lat_we;
        m0_gnt    = (win_q == M0);
        m1_gnt    = (win_q == M1);
        state_nxt = lat_we ? IDLE : RESP;
      end
      RESP: begin
        m0_rvalid = (win_q == M0);
        m1_rvalid = (win_q == M1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch; the pointer moves only when an access is actually started.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= M1;
      win_q     <= M0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (take) begin
      last      <= win;
      win_q     <= win;
      lat_we    <= (win == M1) ? m1_we    : m0_we;
      lat_addr  <= (win == M1) ? m1_addr  : m0_addr;
      lat_wdata <= (win == M1) ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state == ACCESS) && !lat_we) begin
      if (win_q == M0) begin
        rdata0_q <= mem_rdata;
      end else begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  // The latch only changes on entry to ACCESS, so it doubles as the held bus value.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : randomized + directed bench against a transaction model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [1:0]    pending;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          gnt0, gnt1, rv0, rv1, mem_read, mem_write, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(gnt0), .m0_rvalid(rv0), .m0_rdata(rdata0),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(gnt1), .m1_rvalid(rv1), .m1_rdata(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Fixed-priority instance, both masters issuing writes.
  logic [1:0]    fp_req;
  logic          fp_gnt0, fp_gnt1, fp_rv0, fp_rv1, fp_read, fp_write, fp_busy;
  logic [DW-1:0] fp_rdata0, fp_rdata1, fp_wdata_o;
  logic [DW-1:0] fp_mem_rdata;
  logic [AW-1:0] fp_addr_o;
  assign fp_mem_rdata = 32'h1234_5678;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(fp_req[0]), .m0_we(1'b1), .m0_addr(32'h100), .m0_wdata(32'h11),
    .m0_gnt(fp_gnt0), .m0_rvalid(fp_rv0), .m0_rdata(fp_rdata0),
    .m1_req(fp_req[1]), .m1_we(1'b1), .m1_addr(32'h200), .m1_wdata(32'h22),
    .m1_gnt(fp_gnt1), .m1_rvalid(fp_rv1), .m1_rdata(fp_rdata1),
    .mem_addr(fp_addr_o), .mem_wdata(fp_wdata_o), .mem_read(fp_read),
    .mem_write(fp_write), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an access started at edge e owns the bus until idle_at.
  int            edge_n  = 0;
  int            idle_at = 0;
  int            rv_edge = -1;
  int            rv_w;
  logic [DW-1:0] rv_data;
  logic          m_last;
  logic [DW-1:0] shadow [64];
  logic [1:0]    e_gnt, e_rv;
  logic          e_read, e_write, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return (m_last == 1'b0) ? 1 : 0;
    return r[0] ? 0 : 1;
  endfunction

  task automatic model_reset();
    idle_at = 0; rv_edge = -1; m_last = 1'b1;
    e_gnt = '0; e_rv = '0; e_read = 1'b0; e_write = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  task automatic model_edge();
    int w;
    e_gnt = '0; e_rv = '0; e_read = 1'b0; e_write = 1'b0;
    if (rv_edge == edge_n) begin
      e_rv[rv_w] = 1'b1;
      e_rdata[rv_w] = rv_data;
    end
    if (edge_n >= idle_at && req != 2'b00) begin
      w = pick(req);
      m_last = w[0];
      e_gnt[w] = 1'b1;
      e_addr = addr[w];
      e_wdata = wdata[w];
      if (we[w]) begin
        e_write = 1'b1;
        shadow[addr[w][7:2]] = wdata[w];
        idle_at = edge_n + 2;
      end else begin
        e_read = 1'b1;
        rv_edge = edge_n + 1;
        rv_w = w;
        rv_data = shadow[addr[w][7:2]];
        idle_at = edge_n + 3;
      end
    end
    e_busy = (edge_n <= idle_at - 2);
  endtask

  task automatic check_outputs();
    check("gnt",       {gnt1, gnt0}, e_gnt);
    check("rvalid",    {rv1, rv0},   e_rv);
    check("mem_read",  mem_read,     e_read);
    check("mem_write", mem_write,    e_write);
    check("mem_addr",  mem_addr,     e_addr);
    check("mem_wdata", mem_wdata,    e_wdata);
    check("busy",      busy,         e_busy);
    check("m0_rdata",  rdata0,       e_rdata[0]);
    check("m1_rdata",  rdata1,       e_rdata[1]);
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pending[i] = 1'b1; req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (reset) model_edge();
    @(negedge clk);
    check_outputs();
    if (gnt0) pending[0] = 1'b0;
    if (gnt1) pending[1] = 1'b0;
    req = pending;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((pending != 2'b00 || edge_n < idle_at - 1) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("wait_timeout", 1, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ng;
    int   fp_cnt;
    int   gnt_edge [3];
    logic order [3];

    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hA000_0000 | 32'(i * 4);
      shadow[i] = 32'hA000_0000 | 32'(i * 4);
    end
    mem[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;
    req = '0; we = '0; pending = '0; fp_req = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();

    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs();
    tick(); tick();
    reset = 1'b1;

    // Tie straight after reset: m0, m1, m0.
    issue(0, 1'b0, 32'h40, 32'h0);
    issue(1, 1'b0, 32'h44, 32'h0);
    ng = 0;
    order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1;
    for (int c = 0; c < 30 && ng < 3; c++) begin
      tick();
      if (gnt0 || gnt1) begin
        order[ng] = gnt1;
        ng++;
        if (gnt0 && ng < 3) issue(0, 1'b0, 32'h48, 32'h0);
      end
    end
    check("tie_count", ng, 3);
    check("tie_first", order[0], 0);
    check("tie_second", order[1], 1);
    check("tie_third", order[2], 0);
    wait_done();

    // Single read.
    issue(0, 1'b0, 32'h10, 32'h0);
    tick();
    check("rd_gnt", gnt0, 1);
    check("rd_read", mem_read, 1);
    check("rd_addr", mem_addr, 32'h10);
    tick();
    check("rd_rvalid", rv0, 1);
    check("rd_rdata", rdata0, 32'hDEAD_BEEF);
    tick();
    check("rd_idle", busy, 0);

    // Single write.
    issue(1, 1'b1, 32'h20, 32'hCAFE_F00D);
    tick();
    check("wr_write", mem_write, 1);
    check("wr_addr", mem_addr, 32'h20);
    check("wr_wdata", mem_wdata, 32'hCAFE_F00D);
    check("wr_gnt", {gnt1, gnt0}, 2'b10);
    tick();
    check("wr_no_rvalid", {rv1, rv0}, 2'b00);
    check("wr_idle", busy, 0);

    // Back-to-back reads from m0.
    issue(0, 1'b0, 32'h4, 32'h0);
    ng = 0;
    for (int c = 0; c < 30 && ng < 3; c++) begin
      tick();
      if (gnt0) begin
        gnt_edge[ng] = edge_n;
        ng++;
        if (ng < 3) issue(0, 1'b0, 32'(4 * (ng + 1)), 32'h0);
      end
    end
    wait_done();
    check("b2b_count", ng, 3);
    check("b2b_space1", gnt_edge[1] - gnt_edge[0], 3);
    check("b2b_space2", gnt_edge[2] - gnt_edge[1], 3);
    check("b2b_rdata", rdata0, 32'hA000_000C);

    // Reset during the ACCESS cycle of an m0 read.
    issue(0, 1'b0, 32'h30, 32'h0);
    tick();
    check("rst_gnt", gnt0, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_read_drop", mem_read, 0);
    check("rst_gnt_drop", gnt0, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", rdata0, 0);
    model_reset();
    pending = '0; req = '0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    issue(0, 1'b0, 32'h8, 32'h0);
    tick();
    check("rst_regrant", gnt0, 1);
    tick();
    check("rst_reread", rdata0, 32'hA000_0008);
    wait_done();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pending[i] && $urandom_range(0, 2) == 0)
          issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      tick();
    end
    wait_done();

    // Fixed priority: m1 starves while m0 keeps requesting.
    fp_req = 2'b11;
    fp_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); @(negedge clk);
      check("fp_m1_blocked", fp_gnt1, 0);
      if (fp_gnt0) fp_cnt++;
    end
    check("fp_m0_grants", fp_cnt, 6);
    fp_req[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("fp_gap", {fp_gnt1, fp_gnt0}, 2'b00);
    @(posedge clk); @(negedge clk);
    check("fp_m1_gnt", fp_gnt1, 1);
    check("fp_m1_addr", fp_addr_o, 32'h200);
    fp_req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
